// File: rtl/brush_pkg.sv
// Shared widths, reset constants, button indices and the move-FSM state type
// for the brush controller.
package brush_pkg;

    localparam int COORD_W = 5;
    localparam int RAD_W   = 5;
    localparam int COLOR_W = 8;

    localparam logic [RAD_W-1:0]   RADIUS_RST = 5'd1;
    localparam logic [COLOR_W-1:0] COLOR_RST  = 8'd255;

    // Bit positions of each button inside the debounced button vectors.
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_GROW   = 4;
    localparam int BTN_SHRINK = 5;
    localparam int BTN_PEN    = 6;
    localparam int NUM_BTN    = 7;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } move_state_t;

    // One saturating +1/-1 step. Opposing requests cancel, and the limits
    // hold the value instead of wrapping it.
    function automatic logic [COORD_W-1:0] sat_step(
        input logic [COORD_W-1:0] val,
        input logic               inc,
        input logic               dec,
        input logic [COORD_W-1:0] max_val
    );
        logic [COORD_W-1:0] res;
        res = val;
        if (inc && !dec && (val < max_val)) begin
            res = val + 1'b1;
        end else if (dec && !inc && (val != '0)) begin
            res = val - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/brush_ctrl_debounce.sv
// Two-flop synchronizer followed by a stability counter. The level output
// follows the synchronized input only after it has disagreed for DEBOUNCE
// consecutive cycles. Any bounce back clears the count.
module debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int                CNT_W    = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync_0;
    logic             sync_1;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    // NOTE: non-blocking assignments make sync_1 take the old sync_0, giving two real stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= raw;
            sync_1 <= sync_0;
        end
    end

    // Count consecutive disagreeing cycles and flip the level on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_1 != level) begin
            if (cnt == CNT_LAST) begin
                level <= sync_1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/brush_ctrl.sv
// Brush controller: debounces the buttons, auto-repeats cursor moves,
// clamps the cursor and radius to the canvas, and pulses commit one cycle
// after any visible brush change while the pen is down.
module brush_ctrl
    import brush_pkg::*;
#(
    parameter int WIDTH        = 10,
    parameter int HEIGHT       = 10,
    parameter int MAX_RADIUS   = 7,
    parameter int DEBOUNCE     = 16,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_grow,
    input  logic               btn_shrink,
    input  logic               btn_pen,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               color_load,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [RAD_W-1:0]   radius,
    output logic [COLOR_W-1:0] color,
    output logic               pen_down,
    output logic               commit
);

    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]   DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0]   RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);
    localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] X_RST      = COORD_W'(WIDTH / 2);
    localparam logic [COORD_W-1:0] Y_RST      = COORD_W'(HEIGHT / 2);
    localparam logic [RAD_W-1:0]   R_MAX      = RAD_W'(MAX_RADIUS);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] lvl;
    logic [NUM_BTN-1:0] lvl_d;
    logic [NUM_BTN-1:0] rise;
    logic               move_held;
    logic               move_rise;

    move_state_t        state;
    move_state_t        state_next;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_next;
    logic               step;

    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic [RAD_W-1:0]   radius_next;
    logic [COLOR_W-1:0] color_next;
    logic               pen_next;
    logic               change_evt;
    logic               commit_pend;

    assign raw = {btn_pen, btn_shrink, btn_grow, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .level(lvl[i])
        );
    end

    // Remember last cycle's debounced levels to detect rising edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_d <= '0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise      = lvl & ~lvl_d;
    assign move_held = |lvl[BTN_RIGHT:BTN_UP];
    assign move_rise = |rise[BTN_RIGHT:BTN_UP];

    // Move FSM state and repeat timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Move FSM transitions: a fresh press restarts the delay, expiry repeats.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (move_rise) begin
                    state_next = DELAY;
                    timer_next = DELAY_LOAD;
                end
            end
            DELAY, REPEAT: begin
                if (!move_held) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (move_rise) begin
                    state_next = DELAY;
                    timer_next = DELAY_LOAD;
                end else if (timer == '0) begin
                    state_next = REPEAT;
                    timer_next = RATE_LOAD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Move FSM output: a step on a fresh press or on timer expiry while held.
    always_comb begin
        step = 1'b0;
        case (state)
            IDLE:          step = move_rise;
            DELAY, REPEAT: step = move_held && (move_rise || (timer == '0));
            default:       step = 1'b0;
        endcase
    end

    // Next brush values and the commit-worthy change detection.
    always_comb begin
        x_next      = x;
        y_next      = y;
        if (step) begin
            x_next = sat_step(x, lvl[BTN_RIGHT], lvl[BTN_LEFT], X_MAX);
            y_next = sat_step(y, lvl[BTN_DOWN],  lvl[BTN_UP],   Y_MAX);
        end
        radius_next = sat_step(radius, rise[BTN_GROW], rise[BTN_SHRINK], R_MAX);
        pen_next    = pen_down ^ rise[BTN_PEN];
        color_next  = color_load ? color_in : color;
        change_evt  = (pen_down && ((x_next != x) || (y_next != y) ||
                                    (radius_next != radius) || (color_next != color)))
                    || (!pen_down && pen_next);
    end

    // Brush registers; commit trails the change by one cycle so the
    // downstream image is already settled when it is latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= X_RST;
            y           <= Y_RST;
            radius      <= RADIUS_RST;
            color       <= COLOR_RST;
            pen_down    <= 1'b0;
            commit_pend <= 1'b0;
            commit      <= 1'b0;
        end else begin
            x           <= x_next;
            y           <= y_next;
            radius      <= radius_next;
            color       <= color_next;
            pen_down    <= pen_next;
            commit_pend <= change_evt;
            commit      <= commit_pend;
        end
    end

endmodule
